edid_ddc_reader: RTL and testbench



---
 rtl/ddc_pkg.sv | 26 ++
 rtl/edid_ddc_reader_if.sv | 11 +
 rtl/ddc_qtick.sv | 46 ++++
 rtl/edid_ddc_reader.sv | 211 +++++++++++++++++++++
 tb/tb_edid_ddc_reader.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddc_pkg.sv
// Shared definitions for the EDID DDC reader: FSM encoding, EDID constants and
// the SCL quarter-period helper.
package ddc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RSTART,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_STOP,
    ST_FINISH
  } ddc_state_e;

  localparam logic [6:0]  EDID_DEV_ADDR = 7'h50;
  localparam int          EDID_BYTES    = 128;
  localparam logic [63:0] EDID_HEADER   = 64'h00FF_FFFF_FFFF_FF00;

  // One SCL period is four quarters; integer truncation is intended.
  function automatic int quarter_count(input int sys_freq, input int scl_freq);
    return sys_freq / (scl_freq * 4);
  endfunction

endpackage

// File: rtl/edid_ddc_reader_if.sv
// DDC (I2C) bus wires as seen by the reader (master) and by an EEPROM (slave).
// sda_i is the resolved open-drain line level.
interface edid_ddc_reader_if;
  logic scl;
  logic sda_o;
  logic sda_oe;
  logic sda_i;

  modport master (output scl, output sda_o, output sda_oe, input sda_i);
  modport slave  (input scl, input sda_o, input sda_oe, output sda_i);
endinterface

// File: rtl/ddc_qtick.sv
// SCL quarter-period timebase: a one-cycle tick every QCNT cycles and the
// 2-bit quarter index; both held at zero while disabled.
module ddc_qtick
  import ddc_pkg::*;
#(
  parameter int QCNT = 62
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       tick,
  output logic [1:0] quarter
);
  localparam int CW = (QCNT > 1) ? $clog2(QCNT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    qtr_q, qtr_d;

  always_comb begin
    cnt_d = cnt_q;
    qtr_d = qtr_q;
    tick  = 1'b0;
    if (!en) begin
      cnt_d = '0;
      qtr_d = '0;
    end else if (cnt_q == CW'(QCNT - 1)) begin
      tick  = 1'b1;
      cnt_d = '0;
      qtr_d = qtr_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      qtr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      qtr_q <= qtr_d;
    end
  end

  assign quarter = qtr_q;
endmodule

// File: rtl/edid_ddc_reader.sv
// EDID reader over DDC: I2C master that reads BYTE_NUM bytes from offset 0 of
// the EEPROM and checks the modulo-256 EDID checksum.
module edid_ddc_reader
  import ddc_pkg::*;
#(
  parameter int         SYS_FREQ = 25_000_000,
  parameter int         SCL_FREQ = 100_000,
  parameter logic [6:0] DEV_ADDR = EDID_DEV_ADDR,
  parameter int         BYTE_NUM = EDID_BYTES
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  output logic       ddc_scl,
  output logic       ddc_sda_o,
  output logic       ddc_sda_oe,
  input  logic       ddc_sda_i,
  output logic [7:0] edid_data,
  output logic [6:0] edid_addr,
  output logic       edid_valid,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       cksum_ok,
  output ddc_state_e state_dbg
);
  localparam int QCNT = quarter_count(SYS_FREQ, SCL_FREQ);
  localparam int IW   = (BYTE_NUM > 1) ? $clog2(BYTE_NUM) : 1;

  ddc_state_e    state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [1:0]    wr_idx_q, wr_idx_d;
  logic          smp_q, smp_d;
  logic [IW-1:0] byte_q, byte_d;
  logic [7:0]    data_q, data_d, sum_q, sum_d;
  logic [6:0]    addr_q, addr_d;
  logic          valid_q, valid_d, done_q, done_d;
  logic          err_q, err_d, ck_q, ck_d;
  logic          q_en, q_tick, bit_end, smp_now, last_byte;
  logic [1:0]    quarter;
  logic [7:0]    rd_byte;

  assign q_en = (state_q != ST_IDLE) && (state_q != ST_FINISH);

  ddc_qtick #(.QCNT(QCNT)) u_qtick (
    .clk     (vga_clk),
    .rst_n   (sys_rst_n),
    .en      (q_en),
    .tick    (q_tick),
    .quarter (quarter)
  );

  assign bit_end   = q_tick && (quarter == 2'd3);
  assign smp_now   = q_tick && (quarter == 2'd1);
  assign last_byte = (byte_q == IW'(BYTE_NUM - 1));
  assign rd_byte   = {sh_q[6:0], ddc_sda_i};

  // Bus levels per state; SDA only moves at q0 entry except START/STOP edges.
  always_comb begin
    ddc_scl    = 1'b1;
    ddc_sda_oe = 1'b0;
    case (state_q)
      ST_START, ST_RSTART: begin
        ddc_scl    = (quarter != 2'd3);
        ddc_sda_oe = quarter[1];
      end
      ST_WR_BYTE: begin
        ddc_scl    = ^quarter;
        ddc_sda_oe = ~sh_q[7];
      end
      ST_WR_ACK, ST_RD_BYTE: ddc_scl = ^quarter;
      ST_RD_ACK: begin
        ddc_scl    = ^quarter;
        ddc_sda_oe = ~last_byte;
      end
      ST_STOP: begin
        ddc_scl    = (quarter != 2'd0);
        ddc_sda_oe = ~quarter[1];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    wr_idx_d = wr_idx_q;
    smp_d    = smp_q;
    byte_d   = byte_q;
    data_d   = data_q;
    sum_d    = sum_q;
    addr_d   = addr_q;
    err_d    = err_q;
    ck_d     = ck_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d  = ST_START;
        err_d    = 1'b0;
        ck_d     = 1'b0;
        sum_d    = '0;
        byte_d   = '0;
        addr_d   = '0;
        bit_d    = '0;
        wr_idx_d = '0;
        sh_d     = {DEV_ADDR, 1'b0};
      end
      ST_START, ST_RSTART: if (bit_end) state_d = ST_WR_BYTE;
      ST_WR_BYTE: if (bit_end) begin
        sh_d  = {sh_q[6:0], 1'b0};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = ST_WR_ACK;
      end
      ST_WR_ACK: begin
        if (smp_now) smp_d = ddc_sda_i;
        // Write phase: device address (W), word offset 0, device address (R).
        if (bit_end) begin
          if (smp_q) begin
            err_d   = 1'b1;
            state_d = ST_STOP;
          end else if (wr_idx_q == 2'd0) begin
            sh_d     = 8'h00;
            wr_idx_d = 2'd1;
            state_d  = ST_WR_BYTE;
          end else if (wr_idx_q == 2'd1) begin
            sh_d     = {DEV_ADDR, 1'b1};
            wr_idx_d = 2'd2;
            state_d  = ST_RSTART;
          end else begin
            state_d = ST_RD_BYTE;
          end
        end
      end
      ST_RD_BYTE: begin
        if (smp_now) begin
          sh_d = rd_byte;
          if (bit_q == 3'd7) begin
            valid_d = 1'b1;
            data_d  = rd_byte;
            addr_d  = 7'(byte_q);
            sum_d   = sum_q + rd_byte;
          end
        end
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_RD_ACK;
        end
      end
      ST_RD_ACK: if (bit_end) begin
        if (last_byte) begin
          state_d = ST_STOP;
        end else begin
          byte_d  = byte_q + IW'(1);
          state_d = ST_RD_BYTE;
        end
      end
      ST_STOP: if (bit_end) state_d = ST_FINISH;
      ST_FINISH: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        ck_d    = (sum_q == 8'h00) && !err_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      bit_q    <= '0;
      sh_q     <= '0;
      wr_idx_q <= '0;
      smp_q    <= 1'b0;
      byte_q   <= '0;
      data_q   <= '0;
      sum_q    <= '0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ck_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      wr_idx_q <= wr_idx_d;
      smp_q    <= smp_d;
      byte_q   <= byte_d;
      data_q   <= data_d;
      sum_q    <= sum_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ck_q     <= ck_d;
    end
  end

  assign ddc_sda_o  = 1'b0;
  assign edid_data  = data_q;
  assign edid_addr  = addr_q;
  assign edid_valid = valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign cksum_ok   = ck_q;
  assign state_dbg  = state_q;
endmodule

// File: tb/tb_edid_ddc_reader.sv
// Bench for edid_ddc_reader: a fast instance (QCNT=2) against a behavioural
// EDID EEPROM, plus a default-parameter instance with no slave on the bus.
`timescale 1ns/1ps
module tb_edid_ddc_reader;
  import ddc_pkg::*;

  localparam int W = 15;  // {addr[6:0], data[7:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  // ---------------- fast DUT + EEPROM model ----------------
  edid_ddc_reader_if bus ();
  logic       start = 1'b0;
  logic [7:0] edid_data;
  logic [6:0] edid_addr;
  logic       edid_valid, busy, done, err, cksum_ok;
  ddc_state_e dbg_state;
  logic       s_oe = 1'b0;

  assign bus.sda_i = ~(bus.sda_oe | s_oe);

  edid_ddc_reader #(.SYS_FREQ(800_000), .SCL_FREQ(100_000)) dut (
    .vga_clk(clk), .sys_rst_n(rst_n), .start(start),
    .ddc_scl(bus.scl), .ddc_sda_o(bus.sda_o), .ddc_sda_oe(bus.sda_oe), .ddc_sda_i(bus.sda_i),
    .edid_data(edid_data), .edid_addr(edid_addr), .edid_valid(edid_valid),
    .busy(busy), .done(done), .err(err), .cksum_ok(cksum_ok), .state_dbg(dbg_state)
  );

  logic [7:0] img [128];
  bit         sl_present = 1'b0;
  bit         sl_corrupt = 1'b0;

  function automatic logic [7:0] mem_byte(input logic [7:0] a);
    logic [7:0] b;
    b = img[a[6:0]];
    if (sl_corrupt && a[6:0] == 7'd127) b = b + 8'd1;
    return b;
  endfunction

  int         ph = 0, nb = 0, rxc = 0;
  logic [7:0] rxb = 8'h00, ptr = 8'h00, cur_b, nxt_b;
  logic       rd = 1'b0, mack = 1'b0, scl_p = 1'b1, sda_p = 1'b1;
  int         start_cnt = 0, stop_cnt = 0, ack_cnt = 0, nack_cnt = 0;
  logic       nack_stop = 1'b0;

  assign cur_b = mem_byte(ptr);
  assign nxt_b = mem_byte(ptr + 8'd1);

  always @(negedge clk) begin
    scl_p <= bus.scl;
    sda_p <= bus.sda_i;
    if (!rst_n) begin
      ph <= 0;
      s_oe <= 1'b0;
    end else if (scl_p && bus.scl && sda_p && !bus.sda_i) begin
      ph <= 1; nb <= 0; rxc <= 0; s_oe <= 1'b0;
      start_cnt <= start_cnt + 1;
    end else if (scl_p && bus.scl && !sda_p && bus.sda_i) begin
      ph <= 0; s_oe <= 1'b0;
      stop_cnt <= stop_cnt + 1;
      nack_stop <= mack;
    end else if (!scl_p && bus.scl) begin
      if (ph == 1) begin
        rxb <= {rxb[6:0], bus.sda_i};
        nb <= nb + 1;
      end else if (ph == 4) begin
        mack <= bus.sda_i;
        if (bus.sda_i) nack_cnt <= nack_cnt + 1;
        else ack_cnt <= ack_cnt + 1;
      end
    end else if (scl_p && !bus.scl) begin
      case (ph)
        1: if (nb == 8) begin
          rxc <= rxc + 1;
          if (rxc == 0) begin
            if (sl_present && rxb[7:1] == EDID_DEV_ADDR) begin
              s_oe <= 1'b1; rd <= rxb[0]; ph <= 2;
            end else begin
              ph <= 0;
            end
          end else begin
            ptr <= rxb; s_oe <= 1'b1; ph <= 2;
          end
        end
        2: if (rd) begin
          s_oe <= ~cur_b[7]; nb <= 1; ph <= 3;
        end else begin
          s_oe <= 1'b0; nb <= 0; ph <= 1;
        end
        3: if (nb == 8) begin
          s_oe <= 1'b0; ph <= 4;
        end else begin
          s_oe <= ~cur_b[3'(7 - nb)]; nb <= nb + 1;
        end
        4: begin
          ptr <= ptr + 8'd1;
          if (mack) begin
            ph <= 0; s_oe <= 1'b0;
          end else begin
            s_oe <= ~nxt_b[7]; nb <= 1; ph <= 3;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- fast DUT output monitor ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    if (rst_n && edid_valid) got_q.push_back({edid_addr, edid_data});
    if (done) done_cnt <= done_cnt + 1;
  end

  // ---------------- default-parameter DUT, no slave ----------------
  edid_ddc_reader_if dbus ();
  logic       d_start = 1'b0;
  logic [7:0] d_data;
  logic [6:0] d_addr;
  logic       d_valid, d_busy, d_done, d_err, d_cksum;
  ddc_state_e d_state;

  assign dbus.sda_i = ~dbus.sda_oe;

  edid_ddc_reader dut_def (
    .vga_clk(clk), .sys_rst_n(rst_n), .start(d_start),
    .ddc_scl(dbus.scl), .ddc_sda_o(dbus.sda_o), .ddc_sda_oe(dbus.sda_oe), .ddc_sda_i(dbus.sda_i),
    .edid_data(d_data), .edid_addr(d_addr), .edid_valid(d_valid),
    .busy(d_busy), .done(d_done), .err(d_err), .cksum_ok(d_cksum), .state_dbg(d_state)
  );

  int         cyc = 0;
  int         d_rise [2];
  int         d_rise_cnt = 0, d_stop_cnt = 0, d_valid_cnt = 0, d_done_cnt = 0;
  logic [7:0] d_byte = 8'h00;
  logic       d_scl_p = 1'b1, d_sda_p = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    d_scl_p <= dbus.scl;
    d_sda_p <= dbus.sda_i;
    if (!d_scl_p && dbus.scl) begin
      d_rise_cnt <= d_rise_cnt + 1;
      if (d_rise_cnt < 2) d_rise[d_rise_cnt] <= cyc;
      if (d_rise_cnt < 8) d_byte <= {d_byte[6:0], dbus.sda_i};
    end
    if (d_scl_p && dbus.scl && !d_sda_p && dbus.sda_i) d_stop_cnt <= d_stop_cnt + 1;
    if (d_valid) d_valid_cnt <= d_valid_cnt + 1;
    if (d_done) d_done_cnt <= d_done_cnt + 1;
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic load_expected(input bit corrupt);
    for (int i = 0; i < 128; i++) begin
      logic [7:0] b;
      b = img[i];
      if (corrupt && i == 127) b = b + 8'd1;
      exp_q.push_back({7'(i), b});
    end
  endtask

  task automatic drain_check(input string tag);
    logic [W-1:0] e, g;
    chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      tests++;
      if (e !== g) begin
        failed++;
        $display("FAIL %s_byte idx %0d: got addr %0d data %h, expected addr %0d data %h",
                 tag, e[14:8], g[14:8], g[7:0], e[14:8], e[7:0]);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string name;
    bit    present;
    bit    corrupt;
    bit    exp_err;
    bit    exp_ck;
    int    exp_starts;
    int    exp_acks;
    int    exp_nacks;
  } vec_t;

  vec_t vecs [3];

  initial begin
    logic [63:0] hdr;
    logic [7:0]  s;
    bit          seen;
    int          b_done, b_start, b_stop, b_ack, b_nack;

    vecs[0] = '{"good",    1'b1, 1'b0, 1'b0, 1'b1, 2, 127, 1};
    vecs[1] = '{"corrupt", 1'b1, 1'b1, 1'b0, 1'b0, 2, 127, 1};
    vecs[2] = '{"noslave", 1'b0, 1'b0, 1'b1, 1'b0, 1, 0,   0};

    hdr = EDID_HEADER;
    s = 8'h00;
    for (int i = 0; i < 127; i++) begin
      if (i < 8) img[i] = hdr[63 - 8*i -: 8];
      else img[i] = 8'(i * 37 + 11);
      s = s + img[i];
    end
    img[127] = 8'h00 - s;

    // Reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_scl", bus.scl, 1);
    chk("rst_sda_oe", bus.sda_oe, 0);
    chk("rst_sda_o", bus.sda_o, 0);
    chk("rst_data", edid_data, 0);
    chk("rst_addr", edid_addr, 0);
    chk("rst_valid", edid_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cksum", cksum_ok, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Default parameters, empty bus: SCL timing and address NACK
    @(posedge clk); #1 d_start = 1'b1;
    @(posedge clk); #1 d_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6000 && !seen; i++) begin
      @(negedge clk);
      if (d_done) seen = 1'b1;
    end
    chk("def_done_seen", seen, 1);
    chk("def_err", d_err, 1);
    chk("def_cksum", d_cksum, 0);
    chk("def_busy_at_done", d_busy, 0);
    repeat (10) @(negedge clk);
    chk("def_scl_period", d_rise[1] - d_rise[0], 248);
    chk("def_addr_byte", d_byte, 8'hA0);
    chk("def_stop_cnt", d_stop_cnt, 1);
    chk("def_valid_cnt", d_valid_cnt, 0);
    chk("def_done_cnt", d_done_cnt, 1);

    // Table-driven read scenarios
    for (int v = 0; v < 3; v++) begin
      exp_q.delete();
      got_q.delete();
      sl_present = vecs[v].present;
      sl_corrupt = vecs[v].corrupt;
      if (vecs[v].present) load_expected(vecs[v].corrupt);
      b_done = done_cnt; b_start = start_cnt; b_stop = stop_cnt;
      b_ack = ack_cnt; b_nack = nack_cnt;
      pulse_start();
      wait_done(12000, seen);
      chk({vecs[v].name, "_done_seen"}, seen, 1);
      chk({vecs[v].name, "_err"}, err, vecs[v].exp_err);
      chk({vecs[v].name, "_cksum"}, cksum_ok, vecs[v].exp_ck);
      chk({vecs[v].name, "_busy"}, busy, 0);
      repeat (20) @(negedge clk);
      chk({vecs[v].name, "_done_cnt"}, done_cnt - b_done, 1);
      chk({vecs[v].name, "_starts"}, start_cnt - b_start, vecs[v].exp_starts);
      chk({vecs[v].name, "_stops"}, stop_cnt - b_stop, 1);
      chk({vecs[v].name, "_acks"}, ack_cnt - b_ack, vecs[v].exp_acks);
      chk({vecs[v].name, "_nacks"}, nack_cnt - b_nack, vecs[v].exp_nacks);
      if (vecs[v].exp_nacks == 1) chk({vecs[v].name, "_nack_then_stop"}, nack_stop, 1);
      drain_check(vecs[v].name);
    end

    // Reset during byte 40, then a clean full read
    sl_present = 1'b1;
    sl_corrupt = 1'b0;
    exp_q.delete();
    got_q.delete();
    b_done = done_cnt;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 6000 && !seen; i++) begin
      @(negedge clk);
      if (got_q.size() == 40) seen = 1'b1;
    end
    chk("rstmid_reached_byte40", seen, 1);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_scl", bus.scl, 1);
    chk("rstmid_sda_oe", bus.sda_oe, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_valid", edid_valid, 0);
    chk("rstmid_done", done, 0);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rstmid_no_done", done_cnt - b_done, 0);
    got_q.delete();
    load_expected(1'b0);
    b_done = done_cnt;
    pulse_start();
    wait_done(12000, seen);
    chk("rerun_done_seen", seen, 1);
    chk("rerun_cksum", cksum_ok, 1);
    chk("rerun_err", err, 0);
    repeat (20) @(negedge clk);
    chk("rerun_done_cnt", done_cnt - b_done, 1);
    drain_check("rerun");

    // start while busy is ignored
    load_expected(1'b0);
    b_done = done_cnt;
    pulse_start();
    repeat (200) @(negedge clk);
    pulse_start();
    repeat (3000) @(negedge clk);
    chk("busy_mid_run", busy, 1);
    pulse_start();
    wait_done(12000, seen);
    chk("busy_done_seen", seen, 1);
    chk("busy_cksum", cksum_ok, 1);
    repeat (40) @(negedge clk);
    chk("busy_done_cnt", done_cnt - b_done, 1);
    chk("busy_idle_after", busy, 0);
    drain_check("busy");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
